// File: rtl/conv_pkg.sv
// Types shared between the 3x3 window generator and the convolution stage.
// patch_t indexing is [row][col] of the window, matching input_patch[i][j].
package conv_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef pixel_t [2:0][2:0]  patch_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage. The old entry is read combinationally at the
// same address that is written this cycle, so callers see the value before the write.
module conv_line_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are deliberately not reset: the first two rows of each frame prime them.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, every fully populated 3x3 window out ("valid" convolution).
// Two line buffers hold rows r-1 and r-2; a 3x3 shift register forms the window.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PIX_W-1:0]             pix_in,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    output logic [2:0][2:0][PIX_W-1:0]   patch_out,
    output logic                         patch_valid,
    input  logic                         patch_ready,
    output logic                         frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0]               col_q, col_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [2:0][2:0][PIX_W-1:0]     win_q, win_d;
    logic [2:0][2:0][PIX_W-1:0]     patch_q, patch_d;
    logic                           patch_valid_q, patch_valid_d;
    logic                           frame_done_q, frame_done_d;
    logic                           accept, emit, last_col, last_row;
    logic [PIX_W-1:0]               lb0_rd, lb1_rd;

    // Ready depends only on the output register, never on pix_valid.
    assign pix_ready = !patch_valid_q || patch_ready;
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (col_q == COL_W'(IMG_W - 1));
    assign last_row  = (row_q == ROW_W'(IMG_H - 1));
    assign emit      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (pix_in),
        .rdata_o (lb0_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        win_d         = win_q;
        patch_d       = patch_q;
        patch_valid_d = patch_valid_q && !patch_ready;
        frame_done_d  = 1'b0;

        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix_in;

            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Loading on the same edge as a downstream handshake keeps 1 patch/cycle.
        if (emit) begin
            patch_d       = win_d;
            patch_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            win_q         <= '0;
            patch_q       <= '0;
            patch_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            win_q         <= win_d;
            patch_q       <= patch_d;
            patch_valid_q <= patch_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign patch_out   = patch_q;
    assign patch_valid = patch_valid_q;
    assign frame_done  = frame_done_q;

endmodule
